// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus for the serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    modport master (output start, a, b, input busy, done, diff, bout);
    modport slave  (input start, a, b, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b, LSB first, one full-subtractor cell plus a borrow flop
module serial_subtractor #(parameter int WIDTH = 4) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    state_t           state, nstate;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] nres;
    logic [CW-1:0]    cnt;
    logic             brw, d, brw_n, last;
    // full-subtractor cell on the current LSBs; nres is the result register after this shift
    always_comb begin
        d     = sa[0] ^ sb[0] ^ brw;
        brw_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
        nres  = {d, res};
        last  = cnt == CW'(WIDTH - 1);
    end
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    // next state: start only matters in IDLE, RUN ends on the last bit
    always_comb
        nstate = state == IDLE ? (bus.start ? RUN : IDLE) : (last ? IDLE : RUN);
    // outputs decoded from state
    always_comb
        bus.busy = state == RUN;
    // operand capture, serial shift, and result publication on the final bit only
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            brw      <= 1'b0;
            cnt      <= '0;
            bus.diff <= '0;
            bus.bout <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE && bus.start) begin
                sa  <= bus.a;
                sb  <= bus.b;
                brw <= 1'b0;
                cnt <= '0;
            end else if (state == RUN) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                res <= nres[WIDTH-1:1];
                brw <= brw_n;
                cnt <= cnt + 1'b1;
                if (last) begin
                    bus.diff <= nres;
                    bus.bout <= brw_n;
                    bus.done <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table vectors, corner sequences and sweeps checked through a result scoreboard
module tb_serial_subtractor;
    typedef struct {logic [7:0] d; logic b;} exp_t;
    typedef struct {logic [3:0] a; logic [3:0] b; logic [3:0] d; logic bo;} vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   dcnt4 = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;
    vec_t vt[4];
    serial_subtractor_if #(.WIDTH(4)) b4 ();
    serial_subtractor_if #(.WIDTH(8)) b8 ();
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    // scoreboard for the 4-bit instance
    always @(negedge clk)
        if (rst_n && b4.done) begin
            dcnt4++;
            if (q4.size() == 0) chk("unexpected_done4", 32'(b4.done), 32'(0));
            else begin
                e4 = q4.pop_front();
                chk("diff4", 32'(b4.diff), 32'(e4.d));
                chk("bout4", 32'(b4.bout), 32'(e4.b));
            end
        end
    // scoreboard for the 8-bit instance
    always @(negedge clk)
        if (rst_n && b8.done) begin
            if (q8.size() == 0) chk("unexpected_done8", 32'(b8.done), 32'(0));
            else begin
                e8 = q8.pop_front();
                chk("diff8", 32'(b8.diff), 32'(e8.d));
                chk("bout8", 32'(b8.bout), 32'(e8.b));
            end
        end
    task automatic wait4();
        int n = 0;
        while (!b4.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!b4.done) chk("timeout4", 32'(0), 32'(1));
    endtask
    task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic [3:0] ed, input logic eb);
        b4.start = 1'b1;
        b4.a = x;
        b4.b = y;
        q4.push_back('{d: 8'(ed), b: eb});
        @(negedge clk);
        b4.start = 1'b0;
        wait4();
    endtask
    task automatic run8(input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        logic [7:0] ed;
        ed = x - y;
        b8.start = 1'b1;
        b8.a = x;
        b8.b = y;
        q8.push_back('{d: ed, b: x < y});
        @(negedge clk);
        b8.start = 1'b0;
        while (!b8.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!b8.done) chk("timeout8", 32'(0), 32'(1));
    endtask
    initial begin
        int nb, dp, p1, p2, d0;
        logic [3:0] md;
        vt[0] = '{a: 4'd7, b: 4'd3,  d: 4'd4,  bo: 1'b0};
        vt[1] = '{a: 4'd3, b: 4'd7,  d: 4'd12, bo: 1'b1};
        vt[2] = '{a: 4'd0, b: 4'd15, d: 4'd1,  bo: 1'b1};
        vt[3] = '{a: 4'd9, b: 4'd9,  d: 4'd0,  bo: 1'b0};
        b4.start = 1'b0; b4.a = '0; b4.b = '0;
        b8.start = 1'b0; b8.a = '0; b8.b = '0;
        #1;
        chk("rst_busy", 32'(b4.busy), 32'(0));
        chk("rst_done", 32'(b4.done), 32'(0));
        chk("rst_diff", 32'(b4.diff), 32'(0));
        chk("rst_bout", 32'(b4.bout), 32'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // latency and busy width for a=7, b=3
        b4.start = 1'b1; b4.a = 4'd7; b4.b = 4'd3;
        q4.push_back('{d: 8'd4, b: 1'b0});
        nb = 0; dp = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) b4.start = 1'b0;
            if (b4.busy) nb++;
            if (b4.done && dp == 0) dp = i;
        end
        chk("busy_cycles", 32'(nb), 32'(4));
        chk("done_latency", 32'(dp), 32'(5));
        // table vectors
        for (int i = 0; i < 4; i++) run4(vt[i].a, vt[i].b, vt[i].d, vt[i].bo);
        @(negedge clk);
        // start while busy is ignored
        d0 = dcnt4;
        b4.start = 1'b1; b4.a = 4'd10; b4.b = 4'd4;
        q4.push_back('{d: 8'd6, b: 1'b0});
        @(negedge clk);
        b4.start = 1'b0;
        @(negedge clk);
        b4.start = 1'b1; b4.a = 4'd1; b4.b = 4'd2;
        @(negedge clk);
        b4.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("one_done", 32'(dcnt4 - d0), 32'(1));
        // abort mid-operation
        b4.start = 1'b1; b4.a = 4'd12; b4.b = 4'd5;
        q4.push_back('{d: 8'd7, b: 1'b0});
        @(negedge clk);
        b4.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(b4.busy), 32'(0));
        chk("abort_done", 32'(b4.done), 32'(0));
        chk("abort_diff", 32'(b4.diff), 32'(0));
        chk("abort_bout", 32'(b4.bout), 32'(0));
        q4.delete();
        d0 = dcnt4;
        repeat (8) @(negedge clk);
        chk("abort_no_done", 32'(dcnt4 - d0), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        run4(4'd5, 4'd12, 4'd9, 1'b1);
        @(negedge clk);
        // back-to-back with start held high
        b4.start = 1'b1; b4.a = 4'd15; b4.b = 4'd1;
        q4.push_back('{d: 8'd14, b: 1'b0});
        p1 = 0; p2 = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (b4.done) begin
                if (p1 == 0) begin
                    p1 = i;
                    b4.a = 4'd2; b4.b = 4'd3;
                    q4.push_back('{d: 8'd15, b: 1'b1});
                end else if (p2 == 0) p2 = i;
            end
            if (p1 != 0 && i == p1 + 1) b4.start = 1'b0;
        end
        chk("b2b_first", 32'(p1), 32'(5));
        chk("b2b_second", 32'(p2), 32'(10));
        // exhaustive 4-bit sweep
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
                md = 4'(x - y);
                run4(4'(x), 4'(y), md, x < y);
            end
        // random 8-bit sweep, including the extremes
        run8(8'd0, 8'd255);
        run8(8'd255, 8'd0);
        run8(8'd128, 8'd128);
        for (int i = 0; i < 200; i++) run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        repeat (3) @(negedge clk);
        chk("q4_drained", 32'(q4.size()), 32'(0));
        chk("q8_drained", 32'(q8.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: computes a − b one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Start/busy/done handshake; results are held until the next operation.
- Complement datapath to the team's combinational 2-bit adder, for area-constrained arithmetic paths where operands can wait WIDTH cycles.

Parameters:
- WIDTH, 4, operand and difference width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepted start
- b  input  WIDTH  subtrahend; captured on the accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse; diff/bout valid from this cycle on
- diff  output  WIDTH  (a − b) mod 2^WIDTH
- bout  output  1  final borrow; 1 iff a < b (unsigned)

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n. All state is cleared immediately on rst_n=0.
- Reset values: busy=0, done=0, diff=0, bout=0, state=IDLE. Internal shift registers, bit counter and borrow flop are also 0.
- States: IDLE and RUN.
- IDLE → RUN: on a clk edge with start=1.
  - Load a and b into internal shift registers.
  - Clear the borrow flop and the counter.
  - busy=1 from the following cycle.
- RUN, each edge:
  - d_i = a_i ^ b_i ^ brw.
  - brw' = (~a_i & b_i) | (~(a_i ^ b_i) & brw).
  - Shift d_i into the MSB of the internal result register; shift both operand registers right by 1.
  - Increment the counter.
- RUN → IDLE: on the edge processing bit WIDTH−1 (counter = WIDTH−1).
  - diff ← completed result register; bout ← brw'.
  - done=1 for exactly one cycle; busy=0.
- Latency: start accepted at edge k → done high in the cycle after edge k+WIDTH. busy is high for exactly WIDTH cycles.
- diff and bout update only at completion. Partial results are never visible. Values hold until the next completion or reset.
- start while busy=1: ignored. No queueing, no effect on the operation in flight.
- start high in the done cycle: accepted, because the state is IDLE. Back-to-back throughput is one result per WIDTH+1 cycles.
- start held high continuously: a new operation starts in every IDLE cycle.
- a and b may change freely after capture without affecting the result.
- rst_n asserted mid-operation: the operation is aborted, all outputs go to reset values, and done does not pulse.
- Wrap-around: for a < b, diff is the two's-complement wrap and bout=1. For a = b, diff=0 and bout=0.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=4, a=7, b=3, start for 1 cycle → busy high 4 cycles; done pulses 5 cycles after the start edge; diff=4'b0100, bout=0.
- a=3, b=7 → diff=4'b1100 (12), bout=1. a=0, b=15 → diff=1, bout=1. a=9, b=9 → diff=0, bout=0.
- Start a=10, b=4, then pulse start with a=1, b=2 two cycles later (while busy) → second start ignored; diff=6, bout=0; exactly one done.
- Start a=12, b=5; assert rst_n=0 after 2 RUN cycles → busy, done, diff, bout all 0 immediately. After release, start a=5, b=12 → diff=9, bout=1.
- Back-to-back: hold start=1, a=15, b=1 then a=2, b=3 applied on the done cycle → done pulses at start+5 (diff=14, bout=0) and start+10 (diff=15, bout=1).
- Exhaustive: all 256 (a,b) pairs at WIDTH=4 checked against a reference model ((a−b)&15, a<b). Repeat a random sweep at WIDTH=8.
